// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU/LSU result merge into one register-file write port.
// Optional bypass outputs compiled in with WB_ARBITER_BYPASS_EN.
module wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  byp1_hit,
  output logic                  byp2_hit,
  output logic [DATA_WIDTH-1:0] byp1_data,
  output logic [DATA_WIDTH-1:0] byp2_data
);

  logic                  last_lsu;
  logic                  alu_xfer;
  logic                  lsu_xfer;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] rd_sel;
  logic [DATA_WIDTH-1:0] data_sel;

  // Idle default favours the ALU; on contention the loser of last time wins.
  assign alu_ready = !lsu_valid || (alu_valid && last_lsu);
  assign lsu_ready = lsu_valid && (!alu_valid || !last_lsu);

  assign alu_xfer = alu_valid && alu_ready;
  assign lsu_xfer = lsu_valid && lsu_ready;
  assign xfer     = alu_xfer || lsu_xfer;

  always_comb begin
    rd_sel   = alu_rd;
    data_sel = alu_data;
    unique case (1'b1)
      lsu_xfer: begin
        rd_sel   = lsu_rd;
        data_sel = lsu_data;
      end
      default: begin
        rd_sel   = alu_rd;
        data_sel = alu_data;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen      <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      last_lsu <= 1'b1;
    end else begin
      wen <= xfer && (rd_sel != '0);
      if (xfer) begin
        waddr    <= rd_sel;
        wdata    <= data_sel;
        last_lsu <= lsu_xfer;
      end
    end
  end

`ifdef WB_ARBITER_BYPASS_EN
  assign byp1_hit  = wen && (raddr1 == waddr) && (raddr1 != '0);
  assign byp2_hit  = wen && (raddr2 == waddr) && (raddr2 != '0);
  assign byp1_data = byp1_hit ? wdata : '0;
  assign byp2_data = byp2_hit ? wdata : '0;
`else
  logic byp_unused;
  assign byp_unused = ^{raddr1, raddr2};
  assign byp1_hit   = 1'b0;
  assign byp2_hit   = 1'b0;
  assign byp1_data  = '0;
  assign byp2_data  = '0;
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the register-index width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the register-data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 alu_valid / alu_ready  input / output  1 / 1  SHALL be the ALU result handshake.
REQ-006 alu_rd / alu_data  input  ADDR_WIDTH / DATA_WIDTH  SHALL be the ALU destination index and result.
REQ-007 lsu_valid / lsu_ready  input / output  1 / 1  SHALL be the load-unit result handshake.
REQ-008 lsu_rd / lsu_data  input  ADDR_WIDTH / DATA_WIDTH  SHALL be the load destination index and data.
REQ-009 wen / waddr / wdata  output  1 / ADDR_WIDTH / DATA_WIDTH  SHALL drive the register-file write port.
REQ-010 raddr1 / raddr2  input  ADDR_WIDTH  SHALL be the decode-stage read indices, used for bypass lookup.
REQ-011 byp1_hit / byp2_hit  output  1  SHALL flag that the in-flight write targets raddr1 / raddr2.
REQ-012 byp1_data / byp2_data  output  DATA_WIDTH  SHALL carry the bypass value for raddr1 / raddr2.

Function
REQ-013 A transfer SHALL occur on a source when its valid and ready are both high at a rising edge.
REQ-014 At most one source SHALL be granted per cycle.
REQ-015 The ready output of a source SHALL be combinational from the valid inputs and the last-grant flag only, never from the source's own data.
REQ-016 With only one source valid, that source SHALL get ready=1 and the other ready=0.
REQ-017 With both sources valid, grant SHALL go to the source not granted last; the last-grant flag SHALL update only on a transfer.
REQ-018 With neither source valid, the default ready SHALL be alu_ready=1 and lsu_ready=0; no transfer occurs.
REQ-019 A transfer at edge N SHALL register rd and data into waddr and wdata with wen=1 in cycle N+1 (1-cycle latency, one write per cycle, no back-pressure beyond arbitration).
REQ-020 A transfer with rd == 0 SHALL be accepted (ready honoured) but SHALL produce wen=0 in cycle N+1; waddr and wdata still update.
REQ-021 A cycle with no transfer SHALL be followed by wen=0; waddr and wdata SHALL hold their previous values.
REQ-022 Back-to-back transfers SHALL produce wen=1 on consecutive cycles with no bubble.
REQ-023 bypK_hit SHALL be wen && (raddrK == waddr) && (raddrK != 0), combinational; byp1 and byp2 SHALL be independent, and both may hit simultaneously.
REQ-024 byp1_data / byp2_data SHALL equal wdata whenever their hit is 1, and 0 otherwise.
REQ-025 The last-grant flag SHALL be the only arbitration state; no counters or queues.

Reset
REQ-026 rst_n low SHALL immediately force wen=0, waddr=0, wdata=0 and last-grant=LSU, so the ALU wins the first contention.
REQ-027 Assertion of rst_n mid-transfer SHALL discard the in-flight write; no wen pulse SHALL follow reset release.
REQ-028 After rst_n deasserts, the first transfer SHALL be possible at the first subsequent rising edge.

Configuration
REQ-029 Macro WB_ARBITER_BYPASS_EN defined SHALL compile in the REQ-023/024 bypass logic.
REQ-030 Without WB_ARBITER_BYPASS_EN, byp1_hit, byp2_hit, byp1_data and byp2_data SHALL be tied to 0 and raddr1 and raddr2 SHALL be unused; all other behaviour SHALL be identical.

Verification
REQ-031 ALU only: alu_valid=1, rd=3, data=0xDEADBEEF for one cycle -> next cycle wen=1, waddr=3, wdata=0xDEADBEEF; the cycle after, wen=0.
REQ-032 Contention: both valid for 4 cycles after reset (ALU rd=1, LSU rd=2) -> grants ALU, LSU, ALU, LSU; wen high for 4 consecutive cycles with waddr 1,2,1,2.
REQ-033 x0 discard: lsu_valid=1, lsu_rd=0, data=0x5 -> lsu_ready=1; next cycle wen=0 and byp hits stay 0.
REQ-034 Bypass (macro defined): write rd=7, data=0x1234, with raddr1=raddr2=7 in the write cycle -> byp1_hit=byp2_hit=1, both bypass data 0x1234; with the macro undefined -> all bypass outputs 0.
REQ-035 Async reset: rst_n pulsed low between the edges following a transfer -> wen=0 immediately, no write after release, and the ALU wins the next contention.
REQ-036 Idle hold: a transfer of rd=9, data=0xA5 followed by 3 idle cycles -> wen=0 for those 3 cycles with waddr=9 and wdata=0xA5 held.
